shifter_operand_pipe: RTL and testbench
=======================================

Name: shifter_operand_pipe

Overview:
- Parametrised, pipelined successor of the ARM Val2 generator in the execute stage.
- Adds register-specified shifts (amount from Rs[7:0]), full ARM boundary semantics (LSR/ASR #0 = 32, ROR #0 = RRX), shifter carry-out, and a 2-stage valid/ready pipeline with stall and flush.
- Sits between ID/EX register and ALU; carry_out feeds the status-register update path for logical ops with S=1.

Parameters:
- DATA_W, 32, operand/result width; power of two, minimum 8.
- AMT_W, $clog2(DATA_W), width of the internal reduced shift amount.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low; clears all state.
- flush  in  1  synchronous pipeline kill; drops both stages.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept this cycle.
- shift_operand  in  12  instruction bits [11:0].
- rm_value  in  DATA_W  Rm register value.
- rs_value  in  DATA_W  Rs register value; only [7:0] used.
- imm  in  1  I bit: rotated 8-bit immediate.
- mem  in  1  load/store offset mode; highest priority.
- reg_shift  in  1  instruction bit 4: shift amount from Rs.
- carry_in  in  1  current C flag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- val2  out  DATA_W  second operand.
- carry_out  out  1  shifter carry-out.

Behaviour:
- Reset (rst=0, async): both stage valids 0, val2=0, carry_out=0, out_valid=0; in_ready=1 once rst=1.
- Stage 1 (S1): registers inputs; decodes mode, shift type (00 LSL, 01 LSR, 10 ASR, 11 ROR), raw amount (shift_imm or rs_value[7:0]).
- Stage 2 (S2): performs shift and registers val2/carry_out.
- Latency: request accepted at edge N gives out_valid=1 after edge N+1. Throughput is 1 per cycle with no stall.
- Handshake:
  - Accept when in_valid & in_ready.
  - S2 loads when S2 is empty or out_ready=1.
  - S1 advances when S2 loads.
  - in_ready = !s1_valid | s1_advance.
  - val2/carry_out are held stable while out_valid & !out_ready.
- Flush: clears both valids next edge. A request presented the same cycle is dropped. Flush has priority over accept and advance.
- Mode priority is mem > imm > register.
- mem:
  - val2 = sign-extend(shift_operand[11:0]) to DATA_W.
  - carry_out = carry_in.
- imm:
  - val2 = ROR(zero-extend(imm8), 2*rotate_imm).
  - carry_out = carry_in if rotate_imm==0, else val2[DATA_W-1].
- Register, immediate amount n = shift_operand[11:7]:
  - LSL #0: val2 = Rm, carry_out = carry_in.
  - LSR #0 and ASR #0 mean a shift of 32.
  - ROR #0 is RRX: val2 = {carry_in, Rm[W-1:1]}, carry_out = Rm[0].
- Register, Rs amount n = rs_value[7:0]:
  - n==0: val2 = Rm, carry_out = carry_in, for all types.
  - LSL n==W: val2 = 0, carry_out = Rm[0]. LSL n>W: val2 = 0, carry_out = 0.
  - LSR n==W: val2 = 0, carry_out = Rm[W-1]. LSR n>W: val2 = 0, carry_out = 0.
  - ASR n≥W: val2 = all copies of Rm[W-1], carry_out = Rm[W-1].
  - ROR: reduced amount r = n mod W. If r==0, val2 = Rm and carry_out = Rm[W-1]. Otherwise rotate right by r.
- General carry rule for 0<n<W:
  - LSL: carry_out = Rm[W-n].
  - LSR, ASR, ROR: carry_out = Rm[n-1].
- ASR is arithmetic; the implementation must use a signed operand, never a logical >>>.
- An unused rs_value or carry_in does not affect the result.

Decomposition:
- Package arm_shift_pkg: shift-type localparams SH_LSL/SH_LSR/SH_ASR/SH_ROR, SHIFT_OP_W=12, mode encoding (MODE_MEM/MODE_IMM/MODE_REG).
- Sub-module shift_core: purely combinational; inputs are value, type, amount (8-bit), amount_is_imm, carry_in; outputs are result and carry. It is instanced once in S2. The pipeline module owns only handshake and registers.

Test Plan:
- imm=1, shift_operand=0xFFF (rot=15, imm8=0xFF), carry_in=0 -> val2=0x000003FC, carry_out=0, out_valid two edges after accept.
- Reg, LSR #0, Rm=0x80000001 -> val2=0x00000000, carry_out=1. Reg, ROR #0 (RRX), Rm=0x00000003, carry_in=1 -> val2=0x80000001, carry_out=1.
- reg_shift=1, ASR, Rs=40, Rm=0x80000000 -> val2=0xFFFFFFFF, carry_out=1. Same with LSL, Rs=32, Rm=0x00000001 -> val2=0, carry_out=1. ROR, Rs=32, Rm=0x80000000 -> val2=0x80000000, carry_out=1.
- mem=1 with imm=1, shift_operand=0x804 -> val2=0xFFFFF804 (mem priority), carry_out=carry_in.
- Back-to-back 4 requests, out_ready low 3 cycles mid-stream -> in_ready falls once both stages are full, val2 held stable, no loss or duplication, order preserved.
- flush with both stages full plus a new in_valid -> out_valid=0 next cycle, no stale output. rst low mid-stream -> immediate clear of val2/carry_out/out_valid.

Source files
------------

// File: rtl/arm_shift_pkg.sv
// Shared encodings for the ARM second-operand shifter: shift types, operand mode
// and the width of the instruction operand field.
package arm_shift_pkg;

    localparam int SHIFT_OP_W = 12;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef enum logic [1:0] {
        MODE_MEM = 2'd0,
        MODE_IMM = 2'd1,
        MODE_REG = 2'd2
    } mode_e;

endpackage

// File: rtl/shift_core.sv
// Combinational ARM barrel shifter with full boundary semantics and carry-out.
// Immediate-amount encodings (LSR/ASR #0 = 32, ROR #0 = RRX) are resolved here.
module shift_core
    import arm_shift_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int AMT_W  = $clog2(DATA_W)
) (
    input  logic [DATA_W-1:0] value,
    input  logic [1:0]        shift_type,
    input  logic [7:0]        amount,
    input  logic              amount_is_imm,
    input  logic              carry_in,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    localparam logic [8:0] WIDTH_AMT = 9'(DATA_W);

    logic             rrx;
    logic [8:0]       n;
    logic [AMT_W-1:0] low;
    logic [AMT_W-1:0] neg_low;

    always_comb begin
        rrx = amount_is_imm && (shift_type == SH_ROR) && (amount == 8'd0);
        n   = {1'b0, amount};
        if (amount_is_imm && (amount == 8'd0) &&
            ((shift_type == SH_LSR) || (shift_type == SH_ASR)))
            n = 9'd32;
        // For n < DATA_W the low bits are n itself; for ROR they are n mod DATA_W.
        low     = n[AMT_W-1:0];
        neg_low = AMT_W'(0) - low;
    end

    always_comb begin
        // NOTE: defaults first so every path assigns result/carry and no latch is inferred.
        result = value;
        carry  = carry_in;
        if (rrx) begin
            result = {carry_in, value[DATA_W-1:1]};
            carry  = value[0];
        end else if (n != 9'd0) begin
            case (shift_type)
                SH_LSL: begin
                    if (n < WIDTH_AMT) begin
                        result = value << low;
                        carry  = value[neg_low];
                    end else begin
                        result = '0;
                        carry  = (n == WIDTH_AMT) & value[0];
                    end
                end
                SH_LSR: begin
                    if (n < WIDTH_AMT) begin
                        result = value >> low;
                        carry  = value[low - AMT_W'(1)];
                    end else begin
                        result = '0;
                        carry  = (n == WIDTH_AMT) & value[DATA_W-1];
                    end
                end
                SH_ASR: begin
                    if (n < WIDTH_AMT) begin
                        result = $unsigned($signed(value) >>> low);
                        carry  = value[low - AMT_W'(1)];
                    end else begin
                        result = {DATA_W{value[DATA_W-1]}};
                        carry  = value[DATA_W-1];
                    end
                end
                default: begin
                    if (low == '0) begin
                        carry = value[DATA_W-1];
                    end else begin
                        result = (value >> low) | (value << neg_low);
                        carry  = value[low - AMT_W'(1)];
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/shifter_operand_pipe.sv
// Two-stage valid/ready pipeline producing the ALU second operand (val2) and
// shifter carry-out; S1 decodes and registers, S2 shifts and registers.
module shifter_operand_pipe
    import arm_shift_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int AMT_W  = $clog2(DATA_W)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SHIFT_OP_W-1:0] shift_operand,
    input  logic [DATA_W-1:0]     rm_value,
    input  logic [DATA_W-1:0]     rs_value,
    input  logic                  imm,
    input  logic                  mem,
    input  logic                  reg_shift,
    input  logic                  carry_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     val2,
    output logic                  carry_out
);

    mode_e             d_mode;
    logic [DATA_W-1:0] d_value;
    logic [1:0]        d_type;
    logic [7:0]        d_amt;
    logic              d_amt_imm;

    logic              s1_valid;
    mode_e             s1_mode;
    logic [DATA_W-1:0] s1_value;
    logic [1:0]        s1_type;
    logic [7:0]        s1_amt;
    logic              s1_amt_imm;
    logic              s1_cin;
    logic              s2_valid;

    logic              s2_load;
    logic [DATA_W-1:0] core_result;
    logic              core_carry;
    logic              unused_rs_bits;

    assign unused_rs_bits = ^rs_value[DATA_W-1:8];

    // The immediate form is mapped onto a register-style ROR by 2*rotate_imm, so
    // rotate 0 falls through the n==0 path and keeps carry_in.
    always_comb begin
        d_mode    = MODE_REG;
        d_value   = rm_value;
        d_type    = shift_operand[6:5];
        d_amt     = reg_shift ? rs_value[7:0] : {3'b000, shift_operand[11:7]};
        d_amt_imm = !reg_shift;
        if (mem) begin
            d_mode  = MODE_MEM;
            d_value = DATA_W'($signed(shift_operand));
        end else if (imm) begin
            d_mode    = MODE_IMM;
            d_value   = DATA_W'(shift_operand[7:0]);
            d_type    = SH_ROR;
            d_amt     = {3'b000, shift_operand[11:8], 1'b0};
            d_amt_imm = 1'b0;
        end
    end

    assign s2_load   = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_load;
    assign out_valid = s2_valid;

    shift_core #(
        .DATA_W (DATA_W),
        .AMT_W  (AMT_W)
    ) u_shift_core (
        .value         (s1_value),
        .shift_type    (s1_type),
        .amount        (s1_amt),
        .amount_is_imm (s1_amt_imm),
        .carry_in      (s1_cin),
        .result        (core_result),
        .carry         (core_carry)
    );

    // NOTE: all state uses non-blocking assignments, and the data registers are
    // reset too so val2/carry_out read zero straight out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            s1_mode    <= MODE_REG;
            s1_value   <= '0;
            s1_type    <= SH_LSL;
            s1_amt     <= '0;
            s1_amt_imm <= 1'b0;
            s1_cin     <= 1'b0;
            val2       <= '0;
            carry_out  <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    val2      <= (s1_mode == MODE_MEM) ? s1_value : core_result;
                    carry_out <= (s1_mode == MODE_MEM) ? s1_cin : core_carry;
                end
            end
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_mode    <= d_mode;
                    s1_value   <= d_value;
                    s1_type    <= d_type;
                    s1_amt     <= d_amt;
                    s1_amt_imm <= d_amt_imm;
                    s1_cin     <= carry_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_shifter_operand_pipe.sv
// Self-checking bench for shifter_operand_pipe: directed boundary cases, stall,
// flush and reset scenarios, then randomized traffic against a reference model.
module tb_shifter_operand_pipe;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [11:0]  shift_operand;
    logic [W-1:0] rm_value;
    logic [W-1:0] rs_value;
    logic         imm;
    logic         mem;
    logic         reg_shift;
    logic         carry_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] val2;
    logic         carry_out;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [32:0]  exp_q[$];
    logic         hold_pending = 1'b0;
    logic [32:0]  held;
    int           accepted = 0;
    logic         saw_backpressure = 1'b0;
    logic [7:0]   amt_tbl [9] = '{8'd0, 8'd1, 8'd16, 8'd31, 8'd32, 8'd33, 8'd40, 8'd64, 8'd255};

    always #5 clk = ~clk;

    shifter_operand_pipe #(.DATA_W(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .shift_operand (shift_operand),
        .rm_value      (rm_value),
        .rs_value      (rs_value),
        .imm           (imm),
        .mem           (mem),
        .reg_shift     (reg_shift),
        .carry_in      (carry_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .val2          (val2),
        .carry_out     (carry_out)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: {carry, val2} from the architectural rules using 64-bit arithmetic.
    function automatic logic [32:0] model(input logic [11:0] op, input logic [31:0] rm,
                                          input logic [31:0] rs, input logic i, input logic m,
                                          input logic rsh, input logic cin);
        logic [63:0] w;
        logic [31:0] res;
        logic        c;
        int          n;
        logic [1:0]  t;
        logic [31:0] imm8;
        if (m) return {cin, {20{op[11]}}, op};
        if (i) begin
            imm8 = {24'b0, op[7:0]};
            w    = {imm8, imm8} >> (2 * int'(op[11:8]));
            res  = w[31:0];
            c    = (op[11:8] == 4'd0) ? cin : res[31];
            return {c, res};
        end
        t = op[6:5];
        n = rsh ? int'(rs[7:0]) : int'(op[11:7]);
        if (n == 0) begin
            if (rsh || t == 2'b00) return {cin, rm};
            if (t == 2'b11) return {rm[0], cin, rm[31:1]};
            n = 32;
        end
        case (t)
            2'b00: begin w = {32'b0, rm} << n; res = w[31:0];  c = w[32]; end
            2'b01: begin w = {rm, 32'b0} >> n; res = w[63:32]; c = w[31]; end
            2'b10: begin w = $signed({rm, 32'b0}) >>> n; res = w[63:32]; c = w[31]; end
            default: begin w = {rm, rm} >> (n % 32); res = w[31:0]; c = res[31]; end
        endcase
        return {c, res};
    endfunction

    task automatic set_fields(input logic [11:0] op, input logic [31:0] rm, input logic [31:0] rs,
                              input logic i, input logic m, input logic rsh, input logic cin);
        shift_operand = op; rm_value = rm; rs_value = rs;
        imm = i; mem = m; reg_shift = rsh; carry_in = cin;
    endtask

    task automatic rand_fields();
        logic [31:0] r;
        r = $urandom;
        set_fields(12'($urandom), $urandom, {r[31:8], amt_tbl[$urandom % 9]},
                   ($urandom % 3) == 0, ($urandom % 6) == 0, 1'($urandom), 1'($urandom));
    endtask

    // One cycle of scoreboarded traffic; inputs are set at the falling edge beforehand.
    task automatic tick();
        #1;
        if (hold_pending) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_data", 64'({carry_out, val2}), 64'(held));
        end
        check("in_ready", 64'(in_ready), 64'(!(exp_q.size() == 2 && !out_ready)));
        if (in_valid && !in_ready) saw_backpressure = 1'b1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("spurious_out_valid", 64'(out_valid), 64'd0);
            else check("out_data", 64'({carry_out, val2}), 64'(exp_q.pop_front()));
        end
        hold_pending = out_valid && !out_ready && !flush;
        held         = {carry_out, val2};
        if (flush) exp_q.delete();
        else if (in_valid && in_ready) begin
            exp_q.push_back(model(shift_operand, rm_value, rs_value, imm, mem, reg_shift, carry_in));
            accepted++;
        end
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        for (int k = 0; k < 8 && exp_q.size() != 0; k++) tick();
        check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
        #1 check({tag, "_idle"}, 64'(out_valid), 64'd0);
        @(negedge clk);
    endtask

    // Single request into an empty pipe: checks latency and result.
    task automatic directed(input string tag, input logic [11:0] op, input logic [31:0] rm,
                            input logic [31:0] rs, input logic i, input logic m, input logic rsh,
                            input logic cin, input logic [32:0] exp);
        set_fields(op, rm, rs, i, m, rsh, cin);
        in_valid = 1'b1; out_ready = 1'b1;
        #1 check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 check({tag, "_lat_early"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        #1 check({tag, "_lat_valid"}, 64'(out_valid), 64'd1);
        check(tag, 64'({carry_out, val2}), 64'(exp));
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_fields(12'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_val2", 64'(val2), 64'd0);
        check("reset_carry", 64'(carry_out), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1 check("reset_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        directed("imm_rot15",   12'hFFF, 32'h1234_5678, 32'hDEAD_BEEF, 1, 0, 0, 0, {1'b0, 32'h0000_03FC});
        directed("lsr_imm0",    12'h020, 32'h8000_0001, 32'h0,         0, 0, 0, 0, {1'b1, 32'h0000_0000});
        directed("rrx",         12'h060, 32'h0000_0003, 32'h0,         0, 0, 0, 1, {1'b1, 32'h8000_0001});
        directed("asr_rs40",    12'h050, 32'h8000_0000, 32'd40,        0, 0, 1, 0, {1'b1, 32'hFFFF_FFFF});
        directed("lsl_rs32",    12'h010, 32'h0000_0001, 32'd32,        0, 0, 1, 0, {1'b1, 32'h0000_0000});
        directed("ror_rs32",    12'h070, 32'h8000_0000, 32'd32,        0, 0, 1, 0, {1'b1, 32'h8000_0000});
        directed("mem_prio",    12'h804, 32'hFFFF_0000, 32'd7,         1, 1, 1, 1, {1'b1, 32'hFFFF_F804});
        directed("lsl_rs_gt",   12'h010, 32'hFFFF_FFFF, 32'h0000_0121, 0, 0, 1, 1, {1'b0, 32'h0000_0000});

        // Four back-to-back requests with out_ready low for three cycles mid-stream.
        accepted = 0; saw_backpressure = 1'b0;
        for (int c = 0; c < 12; c++) begin
            rand_fields();
            in_valid  = (accepted < 4);
            out_ready = !(c >= 2 && c <= 4);
            tick();
        end
        check("stall_accepted", 64'(accepted), 64'd4);
        check("stall_backpressure", 64'(saw_backpressure), 64'd1);
        drain("stall");

        // Flush with both stages full and a new request presented the same cycle.
        out_ready = 1'b0; in_valid = 1'b1;
        rand_fields(); tick();
        rand_fields(); tick();
        rand_fields(); flush = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1 check("flush_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        for (int k = 0; k < 3; k++) tick();
        drain("flush");

        // Asynchronous reset mid-stream with a held result.
        out_ready = 1'b0; in_valid = 1'b1;
        set_fields(12'h050, 32'h8000_0000, 32'd40, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0; tick();
        check("pre_reset_valid", 64'(out_valid), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("async_reset_valid", 64'(out_valid), 64'd0);
        check("async_reset_val2", 64'(val2), 64'd0);
        check("async_reset_carry", 64'(carry_out), 64'd0);
        exp_q.delete(); hold_pending = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 800; c++) begin
            rand_fields();
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 4) != 0;
            tick();
        end
        drain("random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
